// File: rtl/pwm_duty_sequencer_if.sv
// Target-duty handshake between the steering/follower logic and the duty sequencer.
//   tgt_duty : requested duty, unsigned 10 bit (master -> slave)
//   tgt_vld  : tgt_duty valid                  (master -> slave)
//   tgt_rdy  : target can be accepted          (slave -> master)
interface pwm_duty_sequencer_if;
    logic [9:0] tgt_duty;
    logic       tgt_vld;
    logic       tgt_rdy;

    modport master (
        output tgt_duty,
        output tgt_vld,
        input  tgt_rdy
    );

    modport slave (
        input  tgt_duty,
        input  tgt_vld,
        output tgt_rdy
    );
endinterface

// File: rtl/pwm_duty_sequencer.sv
// Owns the duty input of the free-running PWM generator. Targets arrive over a valid/ready
// handshake; the applied duty is slew-limited by STEP per PWM period and only changes on the
// period boundary, except for brake which forces 0 immediately.
//   clk       : system clock, shared with the PWM generator
//   rst_n     : asynchronous active-low reset
//   en        : 1 = drive toward latched target, 0 = soft-stop ramp to 0
//   brake     : 1 = force duty to 0 at once, highest priority
//   tgt       : target handshake (slave side)
//   duty      : registered duty to the PWM
//   at_target : registered, 1 in IDLE and HOLD
//   state     : 00 IDLE, 01 RAMP, 10 HOLD, 11 BRAKE
module pwm_duty_sequencer #(
    parameter int unsigned STEP    = 8,
    parameter int unsigned PRD_MAX = 1023
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       brake,
    pwm_duty_sequencer_if.slave        tgt,
    output logic [9:0]                 duty,
    output logic                       at_target,
    output logic [1:0]                 state
);

    localparam int unsigned      CntW    = $clog2(PRD_MAX + 1);
    // A step of 1023 or more reaches any target in one period.
    localparam logic [10:0]      StepC   = (STEP >= 1023) ? 11'd1023 : 11'(STEP);
    localparam logic [CntW-1:0]  PrdMaxC = CntW'(PRD_MAX);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRamp  = 2'b01,
        StHold  = 2'b10,
        StBrake = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic [9:0]      duty_q, duty_d;
    logic [9:0]      tgt_q, tgt_d;
    logic            at_target_q, at_target_d;
    logic [CntW-1:0] prd_cnt_q;

    logic            boundary;
    logic            accept;
    logic [9:0]      eff;
    logic [9:0]      stepped;
    logic [10:0]     sum;
    logic [10:0]     diff;

    // Runs in lockstep with the PWM counter; both are cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prd_cnt_q <= '0;
        end else if (prd_cnt_q == PrdMaxC) begin
            prd_cnt_q <= '0;
        end else begin
            prd_cnt_q <= prd_cnt_q + 1'b1;
        end
    end

    assign boundary    = (prd_cnt_q == PrdMaxC);
    assign tgt.tgt_rdy = (state_q != StBrake) && !brake;
    assign accept      = tgt.tgt_vld && tgt.tgt_rdy;
    assign eff         = en ? tgt_q : 10'd0;

    // Saturating step toward eff in 11 bits so neither direction can wrap.
    always_comb begin
        sum     = {1'b0, duty_q} + StepC;
        diff    = {1'b0, duty_q} - {1'b0, eff};
        stepped = duty_q;
        if (duty_q < eff) begin
            stepped = (sum > {1'b0, eff}) ? eff : sum[9:0];
        end else if (duty_q > eff) begin
            // diff > StepC implies duty_q > StepC, so the subtraction stays positive.
            stepped = (diff <= StepC) ? eff : (duty_q - StepC[9:0]);
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = accept ? tgt.tgt_duty : tgt_q;

        if (brake) begin
            state_d = StBrake;
            duty_d  = '0;
        end else begin
            unique case (state_q)
                StBrake: begin
                    state_d = StIdle;
                    duty_d  = '0;
                    tgt_d   = '0;
                end
                StIdle: begin
                    duty_d = '0;
                    if (en && (eff != 10'd0)) begin
                        state_d = StRamp;
                    end
                end
                StRamp: begin
                    // Uses the target latched before this edge, so an accept on the
                    // boundary only takes effect from the following boundary.
                    if (boundary) begin
                        duty_d = stepped;
                        if (stepped == eff) begin
                            state_d = ((eff == 10'd0) && !en) ? StIdle : StHold;
                        end
                    end
                end
                StHold: begin
                    if (eff != duty_q) begin
                        state_d = StRamp;
                    end
                end
            endcase
        end

        at_target_d = (state_d == StIdle) || (state_d == StHold);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            duty_q      <= '0;
            tgt_q       <= '0;
            at_target_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            tgt_q       <= tgt_d;
            at_target_q <= at_target_d;
        end
    end

    assign duty      = duty_q;
    assign at_target = at_target_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer: one instance with STEP=8 and a second with
// STEP=1023 for the single-step and saturation cases.
module tb_pwm_duty_sequencer;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       brake;
    logic [9:0] duty;
    logic       at_target;
    logic [1:0] state;

    logic       en_b;
    logic       brake_b;
    logic [9:0] duty_b;
    logic       at_target_b;
    logic [1:0] state_b;

    logic [9:0] m_cnt;
    int         n_checks;
    int         n_errors;

    pwm_duty_sequencer_if tgt_if ();
    pwm_duty_sequencer_if tgt_b_if ();

    pwm_duty_sequencer #(
        .STEP    (8),
        .PRD_MAX (1023)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .brake     (brake),
        .tgt       (tgt_if),
        .duty      (duty),
        .at_target (at_target),
        .state     (state)
    );

    pwm_duty_sequencer #(
        .STEP    (1023),
        .PRD_MAX (1023)
    ) u_dut_big (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en_b),
        .brake     (brake_b),
        .tgt       (tgt_b_if),
        .duty      (duty_b),
        .at_target (at_target_b),
        .state     (state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference period counter, aligned with the PWM counter from reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_cnt <= '0;
        else        m_cnt <= m_cnt + 10'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the next boundary edge.
    task automatic next_boundary();
        do tick(); while (m_cnt != 10'd0);
    endtask

    task automatic wait_cnt(input logic [9:0] v);
        while (m_cnt != v) tick();
    endtask

    task automatic send_tgt(input logic [9:0] v);
        tgt_if.tgt_duty = v;
        tgt_if.tgt_vld  = 1'b1;
        tick();
        tgt_if.tgt_vld  = 1'b0;
    endtask

    task automatic send_b(input logic [9:0] v);
        tgt_b_if.tgt_duty = v;
        tgt_b_if.tgt_vld  = 1'b1;
        tick();
        tgt_b_if.tgt_vld  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b1;
        en = 1'b0;
        brake = 1'b0;
        en_b = 1'b0;
        brake_b = 1'b0;
        tgt_if.tgt_duty = '0;
        tgt_if.tgt_vld = 1'b0;
        tgt_b_if.tgt_duty = '0;
        tgt_b_if.tgt_vld = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_duty", duty, 0);
        check("rst_state", state, 0);
        check("rst_at_target", at_target, 1);
        check("rst_tgt_rdy", tgt_if.tgt_rdy, 1);
        #3 rst_n = 1'b1;
        tick();

        // Ramp 0 -> 20 in steps of 8; big-step instance jumps and saturates.
        en = 1'b1;
        en_b = 1'b1;
        send_tgt(10'd20);
        send_b(10'd1020);
        next_boundary();
        check("ramp_p1_duty", duty, 8);
        check("ramp_p1_state", state, 1);
        check("ramp_p1_at", at_target, 0);
        check("big_jump_duty", duty_b, 1020);
        check("big_jump_state", state_b, 2);
        send_b(10'd1023);
        wait_cnt(10'd1023);
        check("mid_period_stable", duty, 8);
        next_boundary();
        check("ramp_p2_duty", duty, 16);
        check("big_sat_duty", duty_b, 1023);
        check("big_sat_state", state_b, 2);
        send_b(10'd0);
        next_boundary();
        check("ramp_p3_duty", duty, 20);
        check("ramp_p3_state", state, 2);
        check("ramp_p3_at", at_target, 1);
        check("big_down_duty", duty_b, 0);
        check("big_down_state", state_b, 2);
        for (int i = 0; i < 3; i++) begin
            next_boundary();
            check("hold_duty", duty, 20);
        end

        // Ramp down 20 -> 12 -> 4, then to 0.
        send_tgt(10'd4);
        next_boundary();
        check("down_p1_duty", duty, 12);
        check("down_p1_state", state, 1);
        next_boundary();
        check("down_p2_duty", duty, 4);
        check("down_p2_state", state, 2);
        send_tgt(10'd0);
        next_boundary();
        check("down_zero_duty", duty, 0);
        check("down_zero_state", state, 2);

        // Brake mid-period while ramping toward 600.
        send_tgt(10'd600);
        repeat (5) next_boundary();
        check("pre_brake_duty", duty, 40);
        wait_cnt(10'd300);
        brake = 1'b1;
        #1;
        check("brake_rdy_comb", tgt_if.tgt_rdy, 0);
        tick();
        check("brake_duty", duty, 0);
        check("brake_state", state, 3);
        check("brake_at", at_target, 0);
        tgt_if.tgt_duty = 10'd77;
        tgt_if.tgt_vld = 1'b1;
        tick();
        check("brake_rdy", tgt_if.tgt_rdy, 0);
        tick();
        tgt_if.tgt_vld = 1'b0;
        brake = 1'b0;
        tick();
        check("unbrake_state", state, 0);
        check("unbrake_duty", duty, 0);
        check("unbrake_at", at_target, 1);
        check("unbrake_rdy", tgt_if.tgt_rdy, 1);
        next_boundary();
        next_boundary();
        check("unbrake_tgt_clr_duty", duty, 0);
        check("unbrake_tgt_clr_state", state, 0);

        // Soft stop from HOLD at 24 and recovery.
        send_tgt(10'd24);
        repeat (3) next_boundary();
        check("hold24_duty", duty, 24);
        check("hold24_state", state, 2);
        en = 1'b0;
        next_boundary();
        check("soft_p1_duty", duty, 16);
        check("soft_p1_state", state, 1);
        next_boundary();
        check("soft_p2_duty", duty, 8);
        next_boundary();
        check("soft_p3_duty", duty, 0);
        check("soft_p3_state", state, 0);
        check("soft_p3_at", at_target, 1);
        en = 1'b1;
        next_boundary();
        check("resume_p1_duty", duty, 8);
        next_boundary();
        next_boundary();
        check("resume_p3_duty", duty, 24);
        check("resume_p3_state", state, 2);

        // Accept on the boundary cycle uses the old target; then a mid-period reversal.
        send_tgt(10'd40);
        next_boundary();
        check("pre_bnd_acc_duty", duty, 32);
        wait_cnt(10'd1023);
        tgt_if.tgt_duty = 10'd100;
        tgt_if.tgt_vld = 1'b1;
        tick();
        tgt_if.tgt_vld = 1'b0;
        check("bnd_acc_old_tgt", duty, 40);
        next_boundary();
        check("bnd_acc_new_tgt", duty, 48);
        check("bnd_acc_state", state, 1);
        wait_cnt(10'd400);
        send_tgt(10'd0);
        next_boundary();
        check("reverse_duty", duty, 40);
        check("reverse_state", state, 1);

        // Asynchronous reset mid-ramp at 64.
        send_tgt(10'd100);
        repeat (3) next_boundary();
        check("pre_rst_duty", duty, 64);
        wait_cnt(10'd500);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_duty", duty, 0);
        check("async_rst_state", state, 0);
        check("async_rst_at", at_target, 1);
        @(posedge clk);
        #4 rst_n = 1'b1;
        send_tgt(10'd20);
        repeat (1022) tick();
        check("realign_pre_duty", duty, 0);
        check("realign_pre_state", state, 1);
        tick();
        check("realign_duty", duty, 8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
